prog_clock_divider: RTL and testbench

- Multi-channel programmable clock divider that replaces the fixed single-output divider in the RISC-V processor subsystem.
- Each channel produces a 50%-duty derived clock from clk_in, plus one-cycle rise/fall strobes.
- Per-channel run/stop/single-step control, so the processor clock can be free-running or advanced one cycle at a time for debug.
- Divisor and mode changes take effect only at a period boundary, so the derived clocks never glitch.

---
 rtl/clk_div_pkg.sv | 38 +++
 rtl/clk_div_channel.sv | 151 +++++++++++++++
 rtl/prog_clock_divider.sv | 67 ++++++
 tb/tb_prog_clock_divider.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared types for the programmable clock divider.
//   mode_e     : channel mode requested through the config port
//   state_e    : per-channel sequencing state
//   pend_cfg_t : config captured while a channel is mid-period
// Build option: CLK_DIV_EDGE_CNT_EN adds per-channel rising-edge counters.
package clk_div_pkg;

  // Widest half-period a pending config can carry; channels use the low CNT_W bits.
  localparam int PEND_HALF_W = 64;

  typedef enum logic [1:0] {
    MODE_STOP = 2'd0,
    MODE_RUN  = 2'd1,
    MODE_STEP = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2
  } state_e;

  typedef struct packed {
    logic [PEND_HALF_W-1:0] half;
    mode_e                  mode;
    logic                   valid;
  } pend_cfg_t;

  // Encoding 3 is reserved and behaves as STOP.
  function automatic mode_e decode_mode(input logic [1:0] m);
    case (m)
      2'd1:    return MODE_RUN;
      2'd2:    return MODE_STEP;
      default: return MODE_STOP;
    endcase
  endfunction

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: half-period counter, run/step sequencing and a
// single-entry pending config that is only applied on a falling boundary.
// Build option: CLK_DIV_EDGE_CNT_EN adds edge_cnt (rising edges seen).
// Ports:
//   clk_in, reset           source clock, synchronous active-high reset
//   cfg_valid/cfg_ready     config handshake for this channel
//   cfg_half, cfg_mode      requested half-period (0 -> 1) and mode
//   step_req                single-step request, level sampled
//   clk_out                 derived 50% clock
//   rise_pulse, fall_pulse  one-cycle strobes aligned with clk_out edges
//   busy                    channel is running or stepping
//
// state   | meaning
// ST_IDLE | clk_out held low, counter held at 0
// ST_RUN  | free-running divider
// ST_STEP | one full output period, then back to ST_IDLE
module clk_div_channel #(
  parameter int CNT_W        = 32,
  parameter int DEFAULT_HALF = 2
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_half,
  input  logic [1:0]       cfg_mode,
  input  logic             step_req,
  output logic             clk_out,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic             busy
`ifdef CLK_DIV_EDGE_CNT_EN
  ,
  output logic [31:0]      edge_cnt
`endif
);
  import clk_div_pkg::*;

  localparam logic [CNT_W-1:0] HALF_RST =
    (DEFAULT_HALF < 1) ? CNT_W'(1) : CNT_W'(DEFAULT_HALF);

  state_e           r_state;
  mode_e            r_mode;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_half;
  pend_cfg_t        r_pend;
  logic             r_applied;
  logic             r_clk;
  logic             r_rise;
  logic             r_fall;

  logic             w_cfg_xfer;
  logic             w_tc;
  logic             w_step_go;
  logic [CNT_W-1:0] w_cfg_half;
  mode_e            w_cfg_mode;
  logic             w_unused_pend;

  assign w_cfg_xfer = cfg_valid && !r_pend.valid;
  assign w_cfg_half = (cfg_half == '0) ? CNT_W'(1) : cfg_half;
  assign w_cfg_mode = decode_mode(cfg_mode);
  assign w_tc       = (r_count == (r_half - CNT_W'(1)));
  // Step arming is judged on the mode held before any same-cycle config.
  assign w_step_go  = (r_state == ST_IDLE) && (r_mode == MODE_STEP) && step_req;
  assign w_unused_pend = ^r_pend.half;

  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_state   <= ST_RUN;
      r_mode    <= MODE_RUN;
      r_count   <= '0;
      r_half    <= HALF_RST;
      r_pend    <= '0;
      r_applied <= 1'b0;
      r_clk     <= 1'b0;
      r_rise    <= 1'b0;
      r_fall    <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      // Pending entry stays visible (cfg_ready low) through the fall_pulse cycle.
      if (r_applied) begin
        r_pend.valid <= 1'b0;
        r_applied    <= 1'b0;
      end
      if (r_state == ST_IDLE) begin
        r_count <= '0;
        r_clk   <= 1'b0;
        if (w_step_go) begin
          r_state <= ST_STEP;
          // A config arriving with the step is held until the step period ends.
          if (w_cfg_xfer) begin
            r_pend.half  <= PEND_HALF_W'(w_cfg_half);
            r_pend.mode  <= w_cfg_mode;
            r_pend.valid <= 1'b1;
          end
        end else if (w_cfg_xfer) begin
          r_half <= w_cfg_half;
          r_mode <= w_cfg_mode;
          if (w_cfg_mode == MODE_RUN) r_state <= ST_RUN;
        end
      end else begin
        if (w_cfg_xfer) begin
          r_pend.half  <= PEND_HALF_W'(w_cfg_half);
          r_pend.mode  <= w_cfg_mode;
          r_pend.valid <= 1'b1;
        end
        if (!w_tc) begin
          r_count <= r_count + CNT_W'(1);
        end else begin
          r_count <= '0;
          r_clk   <= !r_clk;
          r_rise  <= !r_clk;
          r_fall  <= r_clk;
          if (r_clk) begin
            if (r_pend.valid && !r_applied) begin
              r_half    <= r_pend.half[CNT_W-1:0];
              r_mode    <= r_pend.mode;
              r_applied <= 1'b1;
              if (r_pend.mode == MODE_RUN) r_state <= ST_RUN;
              else                         r_state <= ST_IDLE;
            end else if (r_state == ST_STEP) begin
              r_state <= ST_IDLE;
            end
          end
        end
      end
    end
  end

  assign cfg_ready  = !r_pend.valid;
  assign clk_out    = r_clk;
  assign rise_pulse = r_rise;
  assign fall_pulse = r_fall;
  assign busy       = (r_state != ST_IDLE);

`ifdef CLK_DIV_EDGE_CNT_EN
  logic        w_rise_ev;
  logic [31:0] r_edge_cnt;

  assign w_rise_ev = (r_state != ST_IDLE) && w_tc && !r_clk;

  always_ff @(posedge clk_in) begin
    if (reset)          r_edge_cnt <= '0;
    else if (w_rise_ev) r_edge_cnt <= r_edge_cnt + 32'd1;
  end

  assign edge_cnt = r_edge_cnt;
`endif

endmodule

// File: rtl/prog_clock_divider.sv
// Multi-channel programmable clock divider with run/stop/single-step control.
// Build option: CLK_DIV_EDGE_CNT_EN adds edge_cnt (32 bits per channel).
// Ports:
//   clk_in, reset                  source clock, synchronous active-high reset
//   cfg_valid/cfg_ready, cfg_ch    config handshake, ready reflects cfg_ch
//   cfg_half, cfg_mode             half-period and mode for channel cfg_ch
//   step_req[NUM_CH]               per-channel single-step request
//   clk_out, rise_pulse, fall_pulse, busy  per-channel outputs
module prog_clock_divider #(
  parameter int  NUM_CH       = 2,
  parameter int  CNT_W        = 32,
  parameter int  DEFAULT_HALF = 2,
  localparam int CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_half,
  input  logic [1:0]        cfg_mode,
  input  logic [NUM_CH-1:0] step_req,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] rise_pulse,
  output logic [NUM_CH-1:0] fall_pulse,
  output logic [NUM_CH-1:0] busy
`ifdef CLK_DIV_EDGE_CNT_EN
  ,
  output logic [NUM_CH*32-1:0] edge_cnt
`endif
);
  import clk_div_pkg::*;

  logic [NUM_CH-1:0] w_ready;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clk_div_channel #(
      .CNT_W        (CNT_W),
      .DEFAULT_HALF (DEFAULT_HALF)
    ) u_ch (
      .clk_in     (clk_in),
      .reset      (reset),
      .cfg_valid  (cfg_valid && (cfg_ch == CH_W'(i))),
      .cfg_ready  (w_ready[i]),
      .cfg_half   (cfg_half),
      .cfg_mode   (cfg_mode),
      .step_req   (step_req[i]),
      .clk_out    (clk_out[i]),
      .rise_pulse (rise_pulse[i]),
      .fall_pulse (fall_pulse[i]),
      .busy       (busy[i])
`ifdef CLK_DIV_EDGE_CNT_EN
      ,
      .edge_cnt   (edge_cnt[i*32 +: 32])
`endif
    );
  end

  // An out-of-range channel index never reports ready, so nothing transfers.
  always_comb begin
    cfg_ready = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_ch == CH_W'(i)) cfg_ready = w_ready[i];
    end
  end

endmodule

// File: tb/tb_prog_clock_divider.sv
module tb_prog_clock_divider;
  localparam int NUM_CH   = 3;
  localparam int CNT_W    = 32;
  localparam int DEF_HALF = 2;
  localparam int CH_W     = 2;

  logic              clk_in = 1'b0;
  logic              reset;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [CH_W-1:0]   cfg_ch;
  logic [CNT_W-1:0]  cfg_half;
  logic [1:0]        cfg_mode;
  logic [NUM_CH-1:0] step_req;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] rise_pulse;
  logic [NUM_CH-1:0] fall_pulse;
  logic [NUM_CH-1:0] busy;
`ifdef CLK_DIV_EDGE_CNT_EN
  logic [NUM_CH*32-1:0] edge_cnt;
`endif

  prog_clock_divider #(
    .NUM_CH       (NUM_CH),
    .CNT_W        (CNT_W),
    .DEFAULT_HALF (DEF_HALF)
  ) u_dut (
    .clk_in     (clk_in),
    .reset      (reset),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_ch     (cfg_ch),
    .cfg_half   (cfg_half),
    .cfg_mode   (cfg_mode),
    .step_req   (step_req),
    .clk_out    (clk_out),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .busy       (busy)
`ifdef CLK_DIV_EDGE_CNT_EN
    ,
    .edge_cnt   (edge_cnt)
`endif
  );

  always #5 clk_in = ~clk_in;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: m_k counts edges since the channel's period origin;
  // the output level is the parity of completed half-periods.
  bit m_run      [NUM_CH];
  bit m_stepping [NUM_CH];
  int m_mode     [NUM_CH];
  int m_half     [NUM_CH];
  int m_k        [NUM_CH];
  bit m_pv       [NUM_CH];
  bit m_pclr     [NUM_CH];
  int m_ph       [NUM_CH];
  int m_pm       [NUM_CH];
  logic [NUM_CH-1:0] e_clk, e_rise, e_fall, e_busy;
`ifdef CLK_DIV_EDGE_CNT_EN
  logic [31:0] m_edges [NUM_CH];
`endif

  task automatic chk(input string tag, input logic [NUM_CH-1:0] obs, input logic [NUM_CH-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs == exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    for (int c = 0; c < NUM_CH; c++) begin
      bit xfer;
      int h;
      int md;
      xfer = cfg_valid && (int'(cfg_ch) == c) && !m_pv[c];
      h    = (cfg_half == '0) ? 1 : int'(cfg_half);
      md   = (cfg_mode == 2'd1) ? 1 : ((cfg_mode == 2'd2) ? 2 : 0);
      e_rise[c] = 1'b0;
      e_fall[c] = 1'b0;
      if (reset) begin
        m_run[c] = 1; m_stepping[c] = 0; m_mode[c] = 1; m_half[c] = DEF_HALF;
        m_k[c] = 0; m_pv[c] = 0; m_pclr[c] = 0; e_clk[c] = 1'b0;
`ifdef CLK_DIV_EDGE_CNT_EN
        m_edges[c] = '0;
`endif
      end else begin
        if (m_pclr[c]) begin m_pv[c] = 0; m_pclr[c] = 0; end
        if (!m_run[c] && !m_stepping[c]) begin
          if (m_mode[c] == 2 && step_req[c]) begin
            m_stepping[c] = 1; m_k[c] = 0;
            if (xfer) begin m_pv[c] = 1; m_ph[c] = h; m_pm[c] = md; end
          end else if (xfer) begin
            m_half[c] = h; m_mode[c] = md; m_run[c] = (md == 1); m_k[c] = 0;
          end
        end else begin
          m_k[c]++;
          if (m_k[c] % m_half[c] == 0) begin
            if ((m_k[c] / m_half[c]) % 2 == 1) begin
              e_rise[c] = 1'b1; e_clk[c] = 1'b1;
`ifdef CLK_DIV_EDGE_CNT_EN
              m_edges[c] = m_edges[c] + 32'd1;
`endif
            end else begin
              e_fall[c] = 1'b1; e_clk[c] = 1'b0;
              if (m_pv[c]) begin
                m_half[c] = m_ph[c]; m_mode[c] = m_pm[c]; m_run[c] = (m_pm[c] == 1);
                m_stepping[c] = 0; m_k[c] = 0; m_pclr[c] = 1;
              end else if (m_stepping[c]) begin
                m_stepping[c] = 0;
              end
            end
          end
          if (xfer) begin m_pv[c] = 1; m_ph[c] = h; m_pm[c] = md; end
        end
      end
      e_busy[c] = m_run[c] || m_stepping[c];
    end
  endtask

  task automatic tick();
    logic rdy_exp;
    @(posedge clk_in);
    model_edge();
    #1;
    chk("clk_out", clk_out, e_clk);
    chk("rise_pulse", rise_pulse, e_rise);
    chk("fall_pulse", fall_pulse, e_fall);
    chk("busy", busy, e_busy);
    rdy_exp = 1'b0;
    if (int'(cfg_ch) < NUM_CH) rdy_exp = !m_pv[int'(cfg_ch)];
    chk_bit("cfg_ready", cfg_ready, rdy_exp);
`ifdef CLK_DIV_EDGE_CNT_EN
    for (int c = 0; c < NUM_CH; c++) chk_int("edge_cnt", int'(edge_cnt[c*32 +: 32]), int'(m_edges[c]));
`endif
  endtask

  task automatic send_cfg(input int ch, input int half, input int mode);
    bit rdy;
    bit done;
    done      = 0;
    cfg_valid = 1'b1;
    cfg_ch    = CH_W'(ch);
    cfg_half  = CNT_W'(half);
    cfg_mode  = 2'(mode);
    for (int i = 0; i < 200 && !done; i++) begin
      #1;
      rdy = cfg_ready;
      tick();
      done = rdy;
    end
    cfg_valid = 1'b0;
    chk_bit("cfg_accept_timeout", done, 1'b1);
  endtask

  // kind 0: clk_out high, 1: fall_pulse, 2: channel idle, 3: rise_pulse
  task automatic wait_cond(input int ch, input int kind);
    bit hit;
    hit = 0;
    for (int i = 0; i < 200 && !hit; i++) begin
      tick();
      case (kind)
        0:       hit = clk_out[ch];
        1:       hit = fall_pulse[ch];
        2:       hit = !busy[ch];
        default: hit = rise_pulse[ch];
      endcase
    end
    chk_bit("wait_timeout", hit, 1'b1);
  endtask

  task automatic measure_period(input int ch, input int exp);
    int n;
    bit seen;
    wait_cond(ch, 3);
    n = 0;
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      tick();
      n++;
      seen = rise_pulse[ch];
    end
    chk_int("period", n, exp);
  endtask

  initial begin
    int rises, falls, busy_cyc;
    reset     = 1'b1;
    cfg_valid = 1'b0;
    cfg_ch    = '0;
    cfg_half  = '0;
    cfg_mode  = 2'd0;
    step_req  = '0;

    // Reset release: first rise two cycles later, period 4.
    tick();
    tick();
    reset = 1'b0;
    tick();
    tick();
    chk_bit("first_rise", rise_pulse[0], 1'b1);
    chk_bit("busy_after_reset", busy[0], 1'b1);
    measure_period(0, 4);

    // Reconfigure while high: pending until the fall, then period 10.
    wait_cond(0, 0);
    send_cfg(0, 5, 1);
    chk_bit("ready_while_pending", cfg_ready, 1'b0);
    wait_cond(0, 1);
    chk_bit("ready_at_apply_fall", cfg_ready, 1'b0);
    tick();
    chk_bit("ready_after_apply", cfg_ready, 1'b1);
    measure_period(0, 10);

    // Single step on channel 1, half 3.
    send_cfg(1, 3, 2);
    wait_cond(1, 2);
    tick();
    tick();
    step_req[1] = 1'b1;
    tick();
    step_req[1] = 1'b0;
    rises = 0; falls = 0; busy_cyc = 0;
    for (int i = 0; i < 14; i++) begin
      if (i > 0) tick();
      rises    += int'(rise_pulse[1]);
      falls    += int'(fall_pulse[1]);
      busy_cyc += int'(busy[1]);
    end
    chk_int("step_rises", rises, 1);
    chk_int("step_falls", falls, 1);
    chk_int("step_busy_cycles", busy_cyc, 6);
    chk_bit("step_clk_idle", clk_out[1], 1'b0);
    // Held request re-triggers only after each return to idle.
    step_req[1] = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    step_req[1] = 1'b0;
    wait_cond(1, 2);

    // half 0 behaves as half 1.
    send_cfg(2, 0, 1);
    wait_cond(2, 1);
    measure_period(2, 2);

    // Reset while high with a pending config.
    wait_cond(0, 0);
    send_cfg(0, 7, 1);
    chk_bit("pre_reset_high", clk_out[0], 1'b1);
    cfg_ch = '0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_bit("reset_clk_low", clk_out[0], 1'b0);
    chk_bit("reset_no_fall", fall_pulse[0], 1'b0);
    chk_bit("reset_ready", cfg_ready, 1'b1);
    measure_period(0, 4);

`ifdef CLK_DIV_EDGE_CNT_EN
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    chk_int("edge_cnt_5", int'(edge_cnt[31:0]), 5);
    force u_dut.g_ch[0].u_ch.r_edge_cnt = 32'hFFFF_FFFF;
    #1;
    release u_dut.g_ch[0].u_ch.r_edge_cnt;
    m_edges[0] = 32'hFFFF_FFFF;
    wait_cond(0, 3);
    chk_int("edge_cnt_wrap", int'(edge_cnt[31:0]), 0);
`endif

    // Randomized traffic against the model.
    for (int it = 0; it < 400; it++) begin
      reset     = ($urandom_range(0, 199) == 0);
      cfg_valid = ($urandom_range(0, 3) == 0);
      cfg_ch    = CH_W'($urandom_range(0, NUM_CH - 1));
      cfg_half  = CNT_W'($urandom_range(0, 5));
      cfg_mode  = 2'($urandom_range(0, 3));
      step_req  = NUM_CH'($urandom_range(0, (1 << NUM_CH) - 1));
      if (cfg_valid) step_req[cfg_ch] = 1'b0;
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
